// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping / unstriping pair.
// Lane count, lane-index width, word layout and serializer FSM encoding.
// Both sides import this package, so the lane ordering cannot drift apart.
package byte_striping_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = 2;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = NUM_LANES * BYTE_W;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Element 0 is lane0, the oldest byte on the serial side.
    typedef logic [NUM_LANES-1:0][BYTE_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stripe_state_e;

endpackage

// File: rtl/unstriping_word_fifo.sv
// Word buffer between lane capture and the serializer: DEPTH x 32-bit entries.
// Latency: a pushed word is visible on pop_dat_o the edge after the push.
// Backpressure: none internally; the caller must gate push on count < DEPTH and pop on count != 0.
module unstriping_word_fifo
    import byte_striping_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] pop_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/byte_unstriping.sv
// Reassembles 4-lane striped words into a serial byte stream, lane0 first.
// Latency: lane0 of a word accepted at edge N into an idle block appears at edge N+2, then one byte per edge.
// Backpressure: lanesReady low when the word buffer is full; all-valid words offered then are dropped.
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk1Mhz,
    input  logic       reset,
    input  logic [7:0] stripedLane0,
    input  logic [7:0] stripedLane1,
    input  logic [7:0] stripedLane2,
    input  logic [7:0] stripedLane3,
    input  logic       lane0VLD,
    input  logic       lane1VLD,
    input  logic       lane2VLD,
    input  logic       lane3VLD,
    output logic       lanesReady,
    output logic [7:0] byteUnstripingOUT,
    output logic       byteUnstripingVLD,
    output logic       laneError
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam lane_idx_t   LAST_LANE = lane_idx_t'(NUM_LANES - 1);

    logic [NUM_LANES-1:0] lane_vld;
    logic                 all_vld;
    logic                 partial_vld;
    logic                 accept;
    word_t                in_word;

    logic [WORD_W-1:0]    fifo_dat;
    logic [AW:0]          fifo_count;
    logic                 fifo_empty;

    stripe_state_e        state_q, state_d;
    lane_idx_t            lane_cnt_q, lane_cnt_d;
    word_t                word_q, word_d;
    logic [BYTE_W-1:0]    out_q, out_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic                 pop;
    logic                 emit;

    assign lane_vld    = {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
    assign all_vld     = &lane_vld;
    assign partial_vld = (|lane_vld) & ~all_vld;
    assign in_word     = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};

    // Ready depends only on registered occupancy, so no input-to-ready path exists.
    assign lanesReady  = (fifo_count < DEPTH_CNT);
    assign accept      = all_vld & lanesReady;
    assign fifo_empty  = (fifo_count == '0);

    unstriping_word_fifo #(
        .DEPTH      (DEPTH)
    ) u_word_fifo (
        .clk_i      (clk1Mhz),
        .rst_i      (reset),
        .push_i     (accept),
        .push_dat_i (in_word),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .count_o    (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk1Mhz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE when a word is buffered, fall back only after the last lane with nothing queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
            ST_SEND: if ((lane_cnt_q == LAST_LANE) && fifo_empty) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next-state; popping on the last lane keeps back-to-back words gapless.
    always_comb begin
        pop        = 1'b0;
        emit       = 1'b0;
        case (state_q)
            ST_IDLE: pop = !fifo_empty;
            ST_SEND: begin
                emit = 1'b1;
                pop  = (lane_cnt_q == LAST_LANE) && !fifo_empty;
            end
            default: begin
                pop  = 1'b0;
                emit = 1'b0;
            end
        endcase
        word_d     = pop  ? word_t'(fifo_dat)  : word_q;
        lane_cnt_d = emit ? lane_cnt_q + 1'b1  : lane_cnt_q;
        out_d      = emit ? word_q[lane_cnt_q] : out_q;
        vld_d      = emit;
        err_d      = err_q | partial_vld;
    end

    // Serializer datapath registers; reset discards any word in flight.
    always_ff @(posedge clk1Mhz or posedge reset) begin
        if (reset) begin
            word_q     <= '0;
            lane_cnt_q <= '0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            word_q     <= word_d;
            lane_cnt_q <= lane_cnt_d;
            out_q      <= out_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    assign byteUnstripingOUT = out_q;
    assign byteUnstripingVLD = vld_q;
    assign laneError         = err_q;

endmodule

// File: tb/tb_byte_unstriping.sv
module tb_byte_unstriping;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] l0, l1, l2, l3;
    logic       v0, v1, v2, v3;
    logic       rdy;
    logic [7:0] bout;
    logic       bvld;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_unstriping #(.DEPTH(DEPTH)) dut (
        .clk1Mhz           (clk),
        .reset             (rst),
        .stripedLane0      (l0),
        .stripedLane1      (l1),
        .stripedLane2      (l2),
        .stripedLane3      (l3),
        .lane0VLD          (v0),
        .lane1VLD          (v1),
        .lane2VLD          (v2),
        .lane3VLD          (v3),
        .lanesReady        (rdy),
        .byteUnstripingOUT (bout),
        .byteUnstripingVLD (bvld),
        .laneError         (err)
    );

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mq[$];     // buffered words
    logic [7:0]  cb[$];     // remaining bytes of word being serialized
    bit          m_loaded;
    logic [7:0]  m_out;
    bit          m_vld;
    bit          m_err;

    function automatic void model_reset();
        mq.delete();
        cb.delete();
        m_loaded = 0;
        m_out    = 8'h00;
        m_vld    = 0;
        m_err    = 0;
    endfunction

    function automatic void model_load(input logic [31:0] w);
        cb.delete();
        for (int i = 0; i < 4; i++) cb.push_back(w[i*8 +: 8]);
        m_loaded = 1;
    endfunction

    function automatic void model_edge(input logic [3:0] v, input logic [31:0] w);
        bit ready_pre;
        ready_pre = (mq.size() < DEPTH);
        m_vld = 0;
        if (m_loaded) begin
            m_out = cb.pop_front();
            m_vld = 1;
            if (cb.size() == 0) begin
                if (mq.size() > 0) model_load(mq.pop_front());
                else m_loaded = 0;
            end
        end else if (mq.size() > 0) begin
            model_load(mq.pop_front());
        end
        if (v == 4'hF) begin
            if (ready_pre) mq.push_back(w);
        end else if (v != 4'h0) begin
            m_err = 1;
        end
    endfunction

    function automatic bit model_rdy();
        return (mq.size() < DEPTH);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] w);
        {v3, v2, v1, v0} = v;
        l0 = w[7:0];
        l1 = w[15:8];
        l2 = w[23:16];
        l3 = w[31:24];
    endtask

    // One clock: inputs applied before the edge, outputs sampled 1 time unit after.
    task automatic cyc(input logic [3:0] v, input logic [31:0] w);
        drive(v, w);
        @(posedge clk);
        model_edge(v, w);
        #1;
    endtask

    task automatic do_reset();
        drive(4'h0, 32'h0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [31:0] w;
        logic        vld;
        logic [7:0]  out;
        logic        rdy;
        logic        err;
    } vec_t;

    localparam logic [31:0] WA = 32'hFFF00F00;  // lanes 00,0F,F0,FF
    localparam logic [31:0] WB = 32'h000FF0FF;  // lanes FF,F0,0F,00

    vec_t   tbl[19];
    logic [7:0] got[$];
    logic [3:0] rv;
    logic [31:0] rw;
    int     r;
    logic   exp_rdy[4];
    logic [7:0] exp_b[4];

    initial begin
        // single word then back-to-back pair, expectations derived by hand
        tbl[0]  = '{4'hF, WA, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{4'h0, 0,  1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{4'h0, 0,  1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{4'h0, 0,  1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[4]  = '{4'h0, 0,  1'b1, 8'hF0, 1'b1, 1'b0};
        tbl[5]  = '{4'h0, 0,  1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6]  = '{4'h0, 0,  1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[7]  = '{4'h0, 0,  1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[8]  = '{4'hF, WA, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[9]  = '{4'hF, WB, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[10] = '{4'h0, 0,  1'b1, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{4'h0, 0,  1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[12] = '{4'h0, 0,  1'b1, 8'hF0, 1'b1, 1'b0};
        tbl[13] = '{4'h0, 0,  1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[14] = '{4'h0, 0,  1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[15] = '{4'h0, 0,  1'b1, 8'hF0, 1'b1, 1'b0};
        tbl[16] = '{4'h0, 0,  1'b1, 8'h0F, 1'b1, 1'b0};
        tbl[17] = '{4'h0, 0,  1'b1, 8'h00, 1'b1, 1'b0};
        tbl[18] = '{4'h0, 0,  1'b0, 8'h00, 1'b1, 1'b0};

        // reset state, checked while reset is held
        drive(4'h0, 32'h0);
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_out", bout, 8'h00);
        chk("rst_vld", bvld, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdy", rdy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;

        // table: single word and back-to-back words
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].v, tbl[i].w);
            chk($sformatf("tbl%0d_vld", i), bvld, tbl[i].vld);
            chk($sformatf("tbl%0d_out", i), bout, tbl[i].out);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
        end

        // backpressure: all-valid held 4 cycles, only 3 words survive
        do_reset();
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        got.delete();
        for (int k = 0; k < 4; k++) begin
            cyc(4'hF, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            chk($sformatf("bp_rdy%0d", k), rdy, exp_rdy[k]);
            if (bvld) got.push_back(bout);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(4'h0, 32'h0);
            if (bvld) got.push_back(bout);
        end
        chk("bp_nbytes", got.size(), 12);
        for (int k = 0; k < got.size() && k < 12; k++)
            chk($sformatf("bp_byte%0d", k), got[k], k);
        chk("bp_err", err, 1'b0);

        // partial valid: dropped, sticky error until reset
        do_reset();
        cyc(4'b0011, 32'hAABBCCDD);
        chk("pv_err_edge", err, 1'b1);
        chk("pv_vld_edge", bvld, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(4'h0, 32'h0);
            chk($sformatf("pv_vld%0d", k), bvld, 1'b0);
            chk($sformatf("pv_err%0d", k), err, 1'b1);
        end
        cyc(4'hF, WA);
        for (int k = 0; k < 6; k++) cyc(4'h0, 32'h0);
        chk("pv_err_sticky", err, 1'b1);
        rst = 1'b1;
        #1;
        chk("pv_err_clr", err, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        // reset mid-word with a second word buffered
        cyc(4'hF, WA);
        cyc(4'hF, WB);
        cyc(4'h0, 32'h0);
        chk("mr_b0", bout, 8'h00);
        cyc(4'h0, 32'h0);
        chk("mr_b1", bout, 8'h0F);
        chk("mr_b1_vld", bvld, 1'b1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("mr_out", bout, 8'h00);
        chk("mr_vld", bvld, 1'b0);
        chk("mr_rdy", rdy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        // fresh word on the first edge after release
        cyc(4'hF, WB);
        chk("mr_acc_vld", bvld, 1'b0);
        cyc(4'h0, 32'h0);
        chk("mr_pop_vld", bvld, 1'b0);
        exp_b = '{8'hFF, 8'hF0, 8'h0F, 8'h00};
        for (int k = 0; k < 4; k++) begin
            cyc(4'h0, 32'h0);
            chk($sformatf("mr_new_vld%0d", k), bvld, 1'b1);
            chk($sformatf("mr_new_b%0d", k), bout, exp_b[k]);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(4'h0, 32'h0);
            chk($sformatf("mr_tail_vld%0d", k), bvld, 1'b0);
        end

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1600; c++) begin
            r  = $urandom_range(0, 9);
            rw = $urandom;
            if (r < 6) rv = 4'hF;
            else if (r < 9 || c < 1000) rv = 4'h0;
            else rv = 4'($urandom_range(1, 14));
            if (c >= 1590) rv = 4'h0;
            cyc(rv, rw);
            chk("rnd_vld", bvld, m_vld);
            chk("rnd_out", bout, m_out);
            chk("rnd_rdy", rdy, model_rdy());
            chk("rnd_err", err, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 4-byte words buffered; it must be a power of 2 and at least 2.
REQ-002 SHALL have port clk1Mhz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports stripedLane0..stripedLane3, input, 8 bits each: byte received on lanes 0..3.
REQ-005 SHALL have ports lane0VLD..lane3VLD, input, 1 bit each: the corresponding lane byte is valid this cycle.
REQ-006 SHALL have port lanesReady, output, 1 bit: the buffer can accept a word this cycle.
REQ-007 SHALL have port byteUnstripingOUT, output, 8 bits: the reassembled serial byte stream.
REQ-008 SHALL have port byteUnstripingVLD, output, 1 bit: byteUnstripingOUT is valid this cycle.
REQ-009 SHALL have port laneError, output, 1 bit: sticky flag indicating a partial-valid lane set was seen.

Function
REQ-010 SHALL accept a word on a rising edge only when all four laneNVLD=1 and lanesReady=1; lane0 is the oldest byte and lane3 the newest.
REQ-011 SHALL drive lanesReady = (stored word count < DEPTH), derived from registered count only (no combinational path from inputs).
REQ-012 SHALL drop an all-valid word presented while lanesReady=0, without error and without state change.
REQ-013 SHALL, when 1-3 lane valids are high in the same cycle, drop the word and set laneError=1 on that edge; laneError holds until reset.
REQ-014 SHALL treat all-zero valids as idle: no action.
REQ-015 SHALL serialize through a two-state FSM: IDLE (no word loaded) and SEND (emitting bytes).
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head word and enter SEND with a 2-bit lane counter at 0.
REQ-017 SHALL, in SEND, register lane[counter] onto byteUnstripingOUT with byteUnstripingVLD=1 and increment the counter, wrapping 3->0.
REQ-018 SHALL, on the counter wrap, pop the next word in the same edge and remain in SEND if the FIFO is non-empty, otherwise return to IDLE; back-to-back words give gapless output.
REQ-019 SHALL output lane0 of a word accepted at edge N into an empty, IDLE block on edge N+2, with lanes 1..3 on N+3..N+5.
REQ-020 SHALL count the FIFO correctly on an accept and a pop in the same edge (count unchanged), and may accept while full only if lanesReady was 1 that cycle.
REQ-021 SHALL drive byteUnstripingVLD=0 and hold byteUnstripingOUT at its last value whenever no byte is emitted.
REQ-022 SHALL wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-023 SHALL, while reset=1, immediately force byteUnstripingOUT=8'h00, byteUnstripingVLD=0, laneError=0, FIFO count/pointers=0, lane counter=0, FSM=IDLE, and therefore lanesReady=1.
REQ-024 SHALL, on reset asserted mid-word, discard the partial word and all buffered words; no residual bytes appear after release.
REQ-025 SHALL accept a word on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL put NUM_LANES=4, the lane-index width (2) and the FSM state encoding (IDLE, SEND) in shared package byte_striping_pkg, which the striping side also uses.
REQ-027 SHALL instantiate the word buffer as the sub-module unstriping_word_fifo (32-bit data, DEPTH entries, push/pop/count); the FSM and serializer live in byte_unstriping.

Verification
REQ-028 SHALL verify a single word: lanes 00,0F,F0,FF with all valids high for one cycle -> bytes 00,0F,F0,FF on edges N+2..N+5, valid high for exactly 4 cycles.
REQ-029 SHALL verify back-to-back words: words {00,0F,F0,FF} and {FF,F0,0F,00} accepted on consecutive ready cycles -> 8 gapless bytes in that order.
REQ-030 SHALL verify backpressure: all-valid held for 4 cycles with DEPTH=2 -> lanesReady drops, a total of exactly 3 words is emitted (1 in flight + 2 buffered), and the extra words are dropped.
REQ-031 SHALL verify partial valid: only lane0VLD=1 and lane1VLD=1 -> no output bytes, laneError=1 from the next edge and sticky until reset.
REQ-032 SHALL verify reset mid-operation: reset asserted after the 2nd byte of word {00,0F,F0,FF} -> outputs 0 immediately, no further bytes, and a fresh word is emitted correctly after release.
